// File: rtl/vga_frame_blitter_if.sv
// Bundles the blitter's game-side inputs, ROM port and VGA-adapter outputs.
// The slave modport is the blitter's view, the master modport is the surrounding system's view.
interface vga_frame_blitter_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 17,
    parameter int NUM_SRC = 4
);
    logic [1:0]                 iGameMode;
    logic                       iVSync;
    logic                       iStart;
    logic                       iFillEn;
    logic [COLOR_W-1:0]         iFillColor;
    logic [NUM_SRC*COLOR_W-1:0] iRomData;
    logic [ADDR_W-1:0]          oRomAddr;
    logic [X_W-1:0]             oX;
    logic [Y_W-1:0]             oY;
    logic [COLOR_W-1:0]         oColor;
    logic                       oWriteEn;
    logic                       oBusy;
    logic                       oDone;
    logic                       oMissed;

    modport slave (
        input  iGameMode, iVSync, iStart, iFillEn, iFillColor, iRomData,
        output oRomAddr, oX, oY, oColor, oWriteEn, oBusy, oDone, oMissed
    );

    modport master (
        output iGameMode, iVSync, iStart, iFillEn, iFillColor, iRomData,
        input  oRomAddr, oX, oY, oColor, oWriteEn, oBusy, oDone, oMissed
    );
endinterface

// File: rtl/vga_frame_blitter.sv
// Copies one H_RES x V_RES frame from a selected image ROM (or a fill colour) into the VGA framebuffer.
// Pixel writes trail their ROM address by ROM_LAT+1 cycles; no backpressure, triggers while busy are dropped and flagged.
module vga_frame_blitter #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 17,
    parameter int NUM_SRC = 4,
    parameter int ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               iResetn,
    vga_frame_blitter_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES*V_RES-1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(H_RES-1);
    localparam int                DRN_W     = $clog2(ROM_LAT+2);
    localparam logic [DRN_W-1:0]  DRN_END   = DRN_W'(ROM_LAT);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic                vs_meta_q, vs_sync_q, vs_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [DRN_W-1:0]    drn_q, drn_d;
    logic [1:0]          sel_q, sel_d;
    logic                fill_q, fill_d;
    logic [COLOR_W-1:0]  fcol_q, fcol_d;
    logic                trig;

    logic [ROM_LAT-1:0]  pv_q;
    logic [X_W-1:0]      px_q [ROM_LAT];
    logic [Y_W-1:0]      py_q [ROM_LAT];
    logic [COLOR_W-1:0]  rom_pix;
    logic                owe_q;
    logic [X_W-1:0]      ox_q;
    logic [Y_W-1:0]      oy_q;
    logic [COLOR_W-1:0]  ocol_q;

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_meta_q <= bus.iVSync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    assign trig = (vs_prev_q & ~vs_sync_q) | bus.iStart;

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drn_q   <= '0;
            sel_q   <= '0;
            fill_q  <= 1'b0;
            fcol_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drn_q   <= drn_d;
            sel_q   <= sel_d;
            fill_q  <= fill_d;
            fcol_q  <= fcol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        drn_d   = drn_q;
        sel_d   = sel_q;
        fill_d  = fill_q;
        fcol_d  = fcol_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SWEEP;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    // Out-of-range modes fall back to source 0.
                    sel_d   = ({30'd0, bus.iGameMode} < 32'(NUM_SRC)) ? bus.iGameMode : 2'd0;
                    fill_d  = bus.iFillEn;
                    fcol_d  = bus.iFillColor;
                end
            end
            SWEEP: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drn_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (x_q == LAST_X) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drn_q == DRN_END) state_d = DONE;
                else                  drn_d   = drn_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_pix = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sel_q == 2'(s)) rom_pix = bus.iRomData[s*COLOR_W +: COLOR_W];
        end
    end

    // Coordinates ride a ROM_LAT-deep shadow pipe so they meet their ROM word at the output register.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            pv_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
            owe_q  <= 1'b0;
            ox_q   <= '0;
            oy_q   <= '0;
            ocol_q <= '0;
        end else begin
            pv_q[0] <= (state_q == SWEEP);
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
            owe_q <= pv_q[ROM_LAT-1];
            if (pv_q[ROM_LAT-1]) begin
                ox_q   <= px_q[ROM_LAT-1];
                oy_q   <= py_q[ROM_LAT-1];
                ocol_q <= fill_q ? fcol_q : rom_pix;
            end
        end
    end

    assign bus.oRomAddr = addr_q;
    assign bus.oX       = ox_q;
    assign bus.oY       = oy_q;
    assign bus.oColor   = ocol_q;
    assign bus.oWriteEn = owe_q;
    assign bus.oBusy    = (state_q == SWEEP) || (state_q == DRAIN);
    assign bus.oDone    = (state_q == DONE);
    assign bus.oMissed  = trig && (state_q != IDLE);
endmodule

// File: tb/tb_vga_frame_blitter.sv
// Bench for vga_frame_blitter on a small 6x4 frame with a 2-cycle, 3-source ROM.
// Expected pixels come from raster arithmetic; expected timing from the trigger-relative cycle rules.
module tb_vga_frame_blitter;
    localparam int H  = 6;
    localparam int V  = 4;
    localparam int N  = H * V;
    localparam int L  = 2;
    localparam int NS = 3;
    localparam int CW = 3;
    localparam int AW = 5;
    localparam int XW = 3;
    localparam int YW = 2;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    pix_t exp_q[$];

    vga_frame_blitter_if #(.X_W(XW), .Y_W(YW), .COLOR_W(CW), .ADDR_W(AW), .NUM_SRC(NS)) bus ();

    vga_frame_blitter #(
        .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .COLOR_W(CW),
        .ADDR_W(AW), .NUM_SRC(NS), .ROM_LAT(L)
    ) dut (
        .clk     (clk),
        .iResetn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] rom_f(input int s, input int a);
        return CW'((a * (s + 1) + s) % 8);
    endfunction

    // ROM sources with L cycles of read latency.
    logic [AW-1:0]    ahist [L];
    logic [NS*CW-1:0] rom_bus;
    always @(posedge clk) begin
        ahist[0] <= bus.oRomAddr;
        for (int i = 1; i < L; i++) ahist[i] <= ahist[i-1];
    end
    always_comb begin
        rom_bus = '0;
        for (int s = 0; s < NS; s++) rom_bus[s*CW +: CW] = rom_f(s, int'(ahist[L-1]));
    end
    assign bus.iRomData = rom_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: trigger at cycle k, then check every cycle up to the first idle cycle after DONE.
    task automatic run_frame(input logic [1:0] mode, input bit fill, input logic [CW-1:0] fc,
                             input bit by_vs, input bit with_start,
                             input int miss_at, input bit miss_vs, input int chg_at);
        int   sel;
        int   wr;
        int   n;
        pix_t p;
        sel = (int'(mode) < NS) ? int'(mode) : 0;
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back('{x: i % H, y: i / H, c: fill ? int'(fc) : int'(rom_f(sel, i))});
        bus.iGameMode  = mode;
        bus.iFillEn    = fill;
        bus.iFillColor = fc;
        if (by_vs) begin
            @(negedge clk);
            bus.iVSync = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        bus.iStart = with_start;
        #1;
        chk("trig_busy", bus.oBusy, 0);
        chk("trig_missed", bus.oMissed, 0);
        wr = 0;
        for (int j = 1; j <= N + L + 3; j++) begin
            @(negedge clk);
            bus.iStart = !miss_vs && (j == miss_at);
            bus.iVSync = miss_vs ? !(j >= miss_at - 2 && j < miss_at) : 1'b1;
            if (j == chg_at) begin
                bus.iGameMode  = 2'($urandom_range(0, 3));
                bus.iFillEn    = ~fill;
                bus.iFillColor = ~fc;
            end
            #1;
            n = j - (2 + L);
            chk("write_en", bus.oWriteEn, (n >= 0 && n < N) ? 1 : 0);
            chk("busy", bus.oBusy, (j >= 1 && j <= 1 + N + L) ? 1 : 0);
            chk("done", bus.oDone, (j == 2 + N + L) ? 1 : 0);
            chk("missed", bus.oMissed, (j == miss_at) ? 1 : 0);
            if (j >= 1 && j <= N) chk("rom_addr", bus.oRomAddr, j - 1);
            if (bus.oWriteEn === 1'b1) begin
                wr++;
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("pix_x", bus.oX, p.x);
                    chk("pix_y", bus.oY, p.y);
                    chk("pix_color", bus.oColor, p.c);
                end
            end
        end
        chk("write_count", wr, N);
        chk("hold_x", bus.oX, H - 1);
        chk("hold_y", bus.oY, V - 1);
    endtask

    initial begin
        bit vs;
        bit st;
        bit mv;
        int ma;
        rst_n          = 1'b0;
        bus.iGameMode  = 2'd0;
        bus.iVSync     = 1'b0;
        bus.iStart     = 1'b0;
        bus.iFillEn    = 1'b0;
        bus.iFillColor = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", bus.oWriteEn, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_x", bus.oX, 0);
        chk("rst_y", bus.oY, 0);
        chk("rst_color", bus.oColor, 0);
        chk("rst_addr", bus.oRomAddr, 0);
        chk("rst_missed", bus.oMissed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // vsync held low through release must not look like a falling edge.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_busy", bus.oBusy, 0);
            chk("post_rst_we", bus.oWriteEn, 0);
        end
        bus.iVSync = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 0, 1'b0, 0);
        run_frame(2'd3, 1'b0, 3'd0, 1'b1, 1'b0, 10, 1'b1, 0);
        run_frame(2'd1, 1'b1, 3'b101, 1'b0, 1'b1, 0, 1'b0, 8);
        run_frame(2'd1, 1'b0, 3'd0, 1'b1, 1'b1, 15, 1'b0, 12);
        run_frame(2'd0, 1'b0, 3'd0, 1'b0, 1'b1, N + L + 2, 1'b0, 0);

        for (int r = 0; r < 5; r++) begin
            vs = 1'($urandom_range(0, 1));
            st = vs ? 1'($urandom_range(0, 1)) : 1'b1;
            mv = 1'($urandom_range(0, 1));
            ma = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, N + L + 2));
            run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 7)),
                      vs, st, ma, mv, int'($urandom_range(0, N)));
        end

        // Abort a frame mid-sweep with reset, then check a clean restart.
        @(negedge clk);
        bus.iStart    = 1'b1;
        bus.iGameMode = 2'd1;
        bus.iFillEn   = 1'b0;
        repeat (2 + L + 10) begin
            @(negedge clk);
            bus.iStart = 1'b0;
        end
        #1;
        chk("pre_rst_we", bus.oWriteEn, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_we", bus.oWriteEn, 0);
        chk("abort_busy", bus.oBusy, 0);
        chk("abort_x", bus.oX, 0);
        chk("abort_y", bus.oY, 0);
        chk("abort_done", bus.oDone, 0);
        chk("abort_addr", bus.oRomAddr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            #1;
            chk("idle_busy", bus.oBusy, 0);
            chk("idle_done", bus.oDone, 0);
            chk("idle_we", bus.oWriteEn, 0);
        end
        run_frame(2'd2, 1'b0, 3'd0, 1'b0, 1'b1, 7, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_frame_blitter.md
Name: vga_frame_blitter

Overview:
- Parametrised successor to the single-image VGA sweep controller.
- Copies one full frame from one of NUM_SRC image ROMs into the VGA adapter framebuffer. The source is selected by game mode.
- A frame starts on a vsync falling edge or a software start. A constant-colour fill mode is also available.
- Handles ROM read latency and reports status through busy, done and missed-trigger signals.
- Sits between the game FSM/ROMs and the VGA adapter's x/y/colour/writeEn inputs.

Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOR_W, 3, colour bits per pixel
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- NUM_SRC, 4, number of image ROM sources
- ROM_LAT, 1, ROM read latency in cycles (>=1)

Ports:
- clk  in  1  system clock
- iResetn  in  1  asynchronous active-low reset
- iGameMode  in  2  source index; values >= NUM_SRC select source 0
- iVSync  in  1  raw VGA vsync; asynchronous, synchronised internally
- iStart  in  1  software start pulse
- iFillEn  in  1  1 = draw iFillColor instead of ROM data
- iFillColor  in  COLOR_W  fill colour
- iRomData  in  NUM_SRC*COLOR_W  packed ROM outputs; source s occupies bits [s*COLOR_W +: COLOR_W]
- oRomAddr  out  ADDR_W  shared ROM read address
- oX  out  X_W  pixel x
- oY  out  Y_W  pixel y
- oColor  out  COLOR_W  pixel colour
- oWriteEn  out  1  pixel write strobe
- oBusy  out  1  frame in progress
- oDone  out  1  one-cycle pulse at frame end
- oMissed  out  1  one-cycle pulse when a trigger is dropped

Behaviour:
- Reset (async, iResetn=0): state goes to IDLE. All outputs and counters are 0. Synchroniser flops are cleared to 0. Reset has immediate effect mid-frame, and there is no resume after release.
- Vsync path: iVSync passes through a 2-flop synchroniser plus an edge register. vs_fall = previous synchronised value 1 and current 0. No falling edge is detected on the first cycle after reset release.
- Trigger: trig = vs_fall OR iStart. Simultaneous vs_fall and iStart count as one trigger.
- States:
  - IDLE: on trig, latch the mode (clamped) and iFillEn/iFillColor, clear the address counter, then go to SWEEP.
  - SWEEP: present oRomAddr = 0..H_RES*V_RES-1, one address per cycle. On the cycle presenting the last address, go to DRAIN.
  - DRAIN: hold for ROM_LAT+1 cycles while the pipeline empties, then go to DONE.
  - DONE: oDone=1 for one cycle, then go to IDLE.
- Latency:
  - The address for pixel n is presented on SWEEP cycle n.
  - oX, oY, oColor and oWriteEn for pixel n are registered and appear ROM_LAT+1 cycles later.
  - x/y/valid travel through a (ROM_LAT+1)-deep pipeline aligned with the data.
  - oColor = iFillColor (latched) when fill is enabled, otherwise the latched source slice of iRomData. Fill mode uses the same latency as ROM mode.
- Raster order: x counts 0..H_RES-1, then wraps to 0 and y increments. The final pixel is (H_RES-1, V_RES-1). Exactly H_RES*V_RES writes occur per frame, and there are no writes outside the frame.
- oBusy is 1 from the first SWEEP cycle through the last oWriteEn cycle inclusive, and 0 in DONE and IDLE.
- oWriteEn=0 means oX/oY/oColor hold their last values.
- Trigger while not IDLE (SWEEP, DRAIN or DONE): the trigger is ignored and oMissed pulses for one cycle. The current frame is unaffected.
- The mode, fill enable and fill colour inputs are sampled only at trigger. Changes mid-frame have no effect.
- Frame length: trigger at cycle k gives the first write at k+2+ROM_LAT, the last write at k+1+H_RES*V_RES+ROM_LAT, and oDone at the cycle after that.

Test Plan:
1. Defaults, mode 2, ROM model = address mod 8 with latency 1, iStart at cycle k:
   - 76800 writes, first at k+3 with (0,0), last at (319,239).
   - colour of every write = address mod 8.
   - oDone exactly at k+76803, oBusy low after.
2. H_RES=4, V_RES=3, ROM_LAT=2, iVSync falling edge:
   - writes occur 4 cycles after the synchronised edge, order (0,0)..(3,0),(0,1)..(3,2).
   - exactly 12 writes.
   - a second vsync edge mid-frame produces one oMissed pulse and no extra writes.
3. Fill mode, iFillColor=3'b101, mode changed mid-frame:
   - all 76800 colours are 5.
   - mode change has no effect.
4. iGameMode=3 with NUM_SRC=2: source 0 data is used.
5. iResetn pulsed low at pixel 1000:
   - oWriteEn, oBusy, oX, oY are 0 immediately.
   - state IDLE, no oDone.
   - the next iStart restarts from (0,0).
6. iStart and vsync falling edge on the same cycle: one frame, no oMissed.
